tms5200_frame_reader: RTL and testbench
=======================================

Name: tms5200_frame_reader

Overview:
- Consumer end of the speech FIFO. Pulls serial bits through the FIFO's shift/fifdso/bytr interface and parses TMS5200 speech frames into parallel parameters for the LPC synthesizer.
- Runs one frame per synthesizer request.
- Tracks bit position within the current FIFO output byte across frames, since frames are not byte-aligned.

Parameters:
- PITCH_BITS, 6, width of the pitch field.
- STARVE_ABORT, 0; 0 = stall while the FIFO is empty; 1 = abort the frame and flag an error on empty.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous, active-low reset
- clk_en  in  1  clock enable; all state advances only when clk_en=1
- clr  in  1  speech flush; same clr that drives the FIFO
- fifdso  in  1  FIFO serial data out, LSB of byte first
- be  in  1  FIFO buffer empty
- shift  out  1  to FIFO: consume one bit
- bytr  out  1  to FIFO: advance to next byte
- req  in  1  synthesizer requests next frame
- busy  out  1  frame parse in progress
- frame_valid  out  1  one clk_en-cycle pulse; parameter outputs valid
- energy  out  4  energy index
- rpt  out  1  repeat flag
- pitch  out  PITCH_BITS  pitch index; 0 means unvoiced
- kpar  out  39  K1..K10 packed MSB-first, widths 5,5,4,4,4,4,4,3,3,3
- silence  out  1  frame had energy 0
- stop  out  1  frame had energy 15
- starved  out  1  waiting on an empty FIFO mid-frame
- underrun  out  1  sticky; set on abort (STARVE_ABORT=1), cleared by clr

Behaviour:
- Reset (reset_n=0 at a clk edge, independent of clk_en): state IDLE, bitpos=0, bytr_pend=0. All outputs 0, including parameter registers.
- clr (clk_en=1): same as reset, except that outputs keep their last values, apart from busy, frame_valid, starved and underrun, which go to 0. clr has priority over every other event.
- States:
  - IDLE: on req, go to FETCH with field=ENERGY and acc=0.
  - FETCH: described in the bullets below.
  - DONE: one cycle; frame_valid=1, then IDLE.
- Field sequence:
  - ENERGY(4). Energy 0 sets silence=1 and the frame ends; energy 15 sets stop=1 and the frame ends.
  - Otherwise RPT(1), then PITCH(PITCH_BITS). If rpt=1 the frame ends and kpar keeps its previous value.
  - Otherwise K1..K4. If pitch=0 the frame ends and K5..K10 are zeroed.
  - Otherwise K5..K10.
- Bit order: field bits are assembled MSB-first, i.e. acc <= {acc, fifdso}. The first bit consumed is the field MSB.
- Shift rule in FETCH: shift=1 exactly when clk_en & !be & !bytr_pend. fifdso is sampled in that same cycle, and bitpos increments mod 8.
- Byte advance:
  - When a shift makes bitpos wrap 7->0, bytr_pend is set.
  - In the next clk_en cycle, bytr=1 and shift=0 in every state, including IDLE and DONE; bytr_pend then clears.
  - bytr is never asserted together with shift.
- Combinational outputs: shift and bytr are decoded from registered state and be. All other outputs are registered.
- Starvation:
  - be=1 in FETCH with bytr_pend=0: starved=1 and no shift.
  - STARVE_ABORT=0: the parse resumes when be drops.
  - STARVE_ABORT=1: underrun=1, go to IDLE, no frame_valid.
- Latency: frame_valid rises one clk_en cycle after the final shift when no stalls occur. Cycle counts from the first FETCH cycle, where bytr cycles are those that fall inside the frame:
  - silence/stop frame: 4 bits, 4 cycles
  - repeat frame: 11 bits, 11 cycles + bytr cycles
  - unvoiced frame: 29 bits
  - voiced frame: 50 bits
- Parameter outputs update on the DONE cycle and hold until the next DONE.
- busy=1 in FETCH and DONE.
- A req arriving while not in IDLE is ignored.

Decomposition:
- Package tms5200_pkg holds:
  - field enum (ENERGY, RPT, PITCH, K1..K10)
  - field width table
  - energy constants E_SILENCE=0, E_STOP=15
  - kpar field offsets
  - state enum
- No sub-module. A single FSM with a bit accumulator, field-width lookup and byte-position counter is natural.

Test Plan:
- Silence frame: FIFO byte 0xF0, req. Expect shift on 4 consecutive clk_en cycles, then frame_valid=1, silence=1, energy=0; bitpos=4, no bytr.
- Stop frame: follow-on req consumes the upper nibble of the same 0xF0? No: load a fresh 0x0F after clr. Expect energy=15, stop=1, frame_valid 4 cycles after start.
- Repeat frame: bytes 0x3A, 0x00, req. Expect energy=5, rpt=1, pitch=32, kpar unchanged. Expect 8 shifts, 1 bytr, 3 shifts, then frame_valid; total 13 clk_en cycles including DONE.
- Starvation: voiced frame with only one byte loaded, STARVE_ABORT=0. Expect starved=1 after the 8th shift and bytr, no shift while be=1. Write remaining bytes, then the parse completes with correct kpar.
- Abort and clr: same stall with STARVE_ABORT=1. Expect underrun=1, IDLE, no frame_valid. Then pulse clr: expect underrun=0, bitpos=0, busy=0.
- Reset mid-frame: assert reset_n=0 during FETCH. Expect all outputs 0 on the next clk edge even with clk_en=0.

Source files
------------

// File: rtl/tms5200_pkg.sv
// tms5200_pkg: shared types and tables for the TMS5200 speech frame reader
package tms5200_pkg;
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DONE} state_t;
  typedef enum logic [3:0] {ENERGY, RPT, PITCH, K1, K2, K3, K4, K5, K6, K7, K8, K9, K10} field_t;
  localparam logic [3:0] E_SILENCE = 4'd0;
  localparam logic [3:0] E_STOP = 4'd15;
  localparam int KPAR_W = 39;
  localparam logic [KPAR_W-1:0] KPAR_K1_4 = 39'h7FFFE00000;
  function automatic logic [3:0] field_width(field_t f, logic [3:0] pitch_bits);
    return f == ENERGY ? 4'd4 : f == RPT ? 4'd1 : f == PITCH ? pitch_bits :
           (f == K1 || f == K2) ? 4'd5 : f >= K8 ? 4'd3 : 4'd4;
  endfunction
  function automatic logic [5:0] kpar_lsb(field_t f);
    case (f)
      K1: return 6'd34;
      K2: return 6'd29;
      K3: return 6'd25;
      K4: return 6'd21;
      K5: return 6'd17;
      K6: return 6'd13;
      K7: return 6'd9;
      K8: return 6'd6;
      K9: return 6'd3;
      default: return 6'd0;
    endcase
  endfunction
endpackage

// File: rtl/tms5200_frame_reader.sv
// tms5200_frame_reader: pulls serial bits from the speech FIFO and parses TMS5200 frames
// clk, reset_n (sync, active low), clk_en, clr (flush)
// FIFO side: fifdso/be in, shift/bytr out (combinational)
// synth side: req in; busy, frame_valid, energy, rpt, pitch, kpar, silence, stop, starved, underrun out
module tms5200_frame_reader
  import tms5200_pkg::*;
#(
  parameter int PITCH_BITS = 6,
  parameter bit STARVE_ABORT = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clk_en,
  input  logic                  clr,
  input  logic                  fifdso,
  input  logic                  be,
  output logic                  shift,
  output logic                  bytr,
  input  logic                  req,
  output logic                  busy,
  output logic                  frame_valid,
  output logic [3:0]            energy,
  output logic                  rpt,
  output logic [PITCH_BITS-1:0] pitch,
  output logic [KPAR_W-1:0]     kpar,
  output logic                  silence,
  output logic                  stop,
  output logic                  starved,
  output logic                  underrun
);
  localparam int AW = PITCH_BITS > 5 ? PITCH_BITS : 5;
  localparam logic [3:0] PB = 4'(PITCH_BITS);
  state_t state, state_n;
  field_t field, field_n;
  logic [3:0] cnt, fw;
  logic [AW-2:0] acc;
  logic [AW-1:0] val;
  logic [2:0] bitpos;
  logic bytr_pend, stall, last, fin;
  logic [3:0] energy_s;
  logic rpt_s;
  logic [PITCH_BITS-1:0] pitch_s;
  logic [KPAR_W-1:0] kpar_s, kpar_n, kmask;
  logic [5:0] klsb;
  always_comb begin
    val = {acc, fifdso};
    shift = clk_en && state == S_FETCH && !be && !bytr_pend;
    bytr = clk_en && bytr_pend;
    stall = state == S_FETCH && be && !bytr_pend;
    fw = field_width(field, PB);
    last = shift && cnt == fw - 4'd1;
    // a frame ends early on silence/stop energy, on repeat, or on unvoiced after K4
    fin = last && (field == ENERGY ? (val[3:0] == E_SILENCE || val[3:0] == E_STOP) :
                   field == PITCH ? rpt_s : field == K4 ? pitch_s == '0 : field == K10);
    field_n = field_t'(field + 4'd1);
    klsb = kpar_lsb(field);
    kmask = ((39'd1 << fw) - 39'd1) << klsb;
    kpar_n = field >= K1 ? (kpar_s & ~kmask) | ({{(KPAR_W-AW){1'b0}}, val} << klsb) : kpar_s;
    state_n = state == S_IDLE ? (req ? S_FETCH : S_IDLE) :
              state == S_DONE ? S_IDLE :
              fin ? S_DONE :
              (stall && STARVE_ABORT) ? S_IDLE : S_FETCH;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) state <= S_IDLE;
    else if (clk_en) state <= clr ? S_IDLE : state_n;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      field <= ENERGY;
      cnt <= '0;
      acc <= '0;
      bitpos <= '0;
      bytr_pend <= 1'b0;
      energy_s <= '0;
      rpt_s <= 1'b0;
      pitch_s <= '0;
      kpar_s <= '0;
      busy <= 1'b0;
      frame_valid <= 1'b0;
      energy <= '0;
      rpt <= 1'b0;
      pitch <= '0;
      kpar <= '0;
      silence <= 1'b0;
      stop <= 1'b0;
      starved <= 1'b0;
      underrun <= 1'b0;
    end else if (clk_en) begin
      if (clr) begin
        bitpos <= '0;
        bytr_pend <= 1'b0;
        busy <= 1'b0;
        frame_valid <= 1'b0;
        starved <= 1'b0;
        underrun <= 1'b0;
      end else begin
        busy <= state_n != S_IDLE;
        frame_valid <= state_n == S_DONE;
        starved <= stall && !STARVE_ABORT;
        if (stall && STARVE_ABORT) underrun <= 1'b1;
        if (shift) bitpos <= bitpos + 3'd1;
        // a wrap 7->0 owes the FIFO one bytr on the next enabled cycle
        bytr_pend <= shift && bitpos == 3'd7;
        if (state == S_IDLE && req) begin
          field <= ENERGY;
          cnt <= '0;
          acc <= '0;
        end else if (shift) begin
          acc <= last ? '0 : val[AW-2:0];
          cnt <= last ? '0 : cnt + 4'd1;
          if (last) begin
            field <= field_n;
            kpar_s <= kpar_n;
            if (field == ENERGY) energy_s <= val[3:0];
            if (field == RPT) rpt_s <= val[0];
            if (field == PITCH) pitch_s <= val[PITCH_BITS-1:0];
            if (fin) begin
              energy <= field == ENERGY ? val[3:0] : energy_s;
              silence <= field == ENERGY && val[3:0] == E_SILENCE;
              stop <= field == ENERGY && val[3:0] == E_STOP;
              if (field != ENERGY) begin
                rpt <= rpt_s;
                pitch <= field == PITCH ? val[PITCH_BITS-1:0] : pitch_s;
              end
              if (field == K4) kpar <= kpar_n & KPAR_K1_4;
              else if (field == K10) kpar <= kpar_n;
            end
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_tms5200_frame_reader.sv
// tb_tms5200_frame_reader: table-driven frame checks plus stall, abort, clr and reset sequences
module tb_tms5200_frame_reader;
  typedef struct {
    logic [3:0]  e;
    logic        r;
    logic [5:0]  p;
    logic [38:0] kp;
    logic [38:0] xk;
    int          lat;
  } row_t;
  logic clk = 1'b0, reset_n, clk_en, clr, req, fifdso, be;
  logic shift, bytr, busy, frame_valid, rpt, silence, stop, starved, underrun;
  logic [3:0] energy;
  logic [5:0] pitch;
  logic [38:0] kpar;
  logic a_shift, a_bytr, a_busy, a_frame_valid, a_rpt, a_silence, a_stop, a_starved, a_underrun;
  logic [3:0] a_energy;
  logic [5:0] a_pitch;
  logic [38:0] a_kpar;
  logic [7:0] mem [16];
  logic [3:0] rd = 4'd0, wr = 4'd0;
  logic [2:0] fb = 3'd0;
  logic [7:0] by [8];
  int ns, nb, n, s0, b0, f0;
  int checks = 0, errors = 0;
  int nsh = 0, nby = 0, nafv = 0, ovl = 0;
  row_t rows [6];

  always #5 clk = ~clk;

  tms5200_frame_reader #(.PITCH_BITS(6), .STARVE_ABORT(1'b0)) u0 (
    .clk(clk), .reset_n(reset_n), .clk_en(clk_en), .clr(clr), .fifdso(fifdso), .be(be),
    .shift(shift), .bytr(bytr), .req(req), .busy(busy), .frame_valid(frame_valid),
    .energy(energy), .rpt(rpt), .pitch(pitch), .kpar(kpar), .silence(silence), .stop(stop),
    .starved(starved), .underrun(underrun));

  tms5200_frame_reader #(.PITCH_BITS(6), .STARVE_ABORT(1'b1)) u1 (
    .clk(clk), .reset_n(reset_n), .clk_en(clk_en), .clr(clr), .fifdso(fifdso), .be(be),
    .shift(a_shift), .bytr(a_bytr), .req(req), .busy(a_busy), .frame_valid(a_frame_valid),
    .energy(a_energy), .rpt(a_rpt), .pitch(a_pitch), .kpar(a_kpar), .silence(a_silence), .stop(a_stop),
    .starved(a_starved), .underrun(a_underrun));

  assign be = rd == wr;
  assign fifdso = mem[rd][fb];

  always @(posedge clk) begin
    if (clk_en) begin
      if (clr) begin
        rd <= wr;
        fb <= 3'd0;
      end else begin
        if (shift) fb <= fb + 3'd1;
        if (bytr) begin
          rd <= rd + 4'd1;
          fb <= 3'd0;
        end
      end
    end
  end

  always @(posedge clk) begin
    if (shift) nsh <= nsh + 1;
    if (bytr) nby <= nby + 1;
    if (a_frame_valid) nafv <= nafv + 1;
    if ((shift && bytr) || (a_shift && a_bytr)) ovl <= ovl + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr] = b;
    wr = wr + 4'd1;
  endtask

  task automatic put(input int v, input int w);
    for (int i = w - 1; i >= 0; i--) begin
      by[ns / 8][ns % 8] = v[i];
      ns++;
    end
  endtask

  task automatic build(input row_t r);
    ns = 0;
    for (int i = 0; i < 8; i++) by[i] = 8'h00;
    put(int'(r.e), 4);
    if (r.e != 4'd0 && r.e != 4'd15) begin
      put(int'(r.r), 1);
      put(int'(r.p), 6);
      if (!r.r) begin
        for (int i = 38; i >= 21; i--) put(int'(r.kp[i]), 1);
        if (r.p != 6'd0) for (int i = 20; i >= 0; i--) put(int'(r.kp[i]), 1);
      end
    end
    nb = (ns + 7) / 8;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  task automatic start();
    req = 1'b1;
    step();
    req = 1'b0;
  endtask

  task automatic wait_fv(output int cyc);
    cyc = 0;
    while (!frame_valid && cyc < 100) begin
      step();
      cyc++;
    end
  endtask

  initial begin
    rows[0] = '{4'd9,  1'b0, 6'd37, 39'h56789ABCDE, 39'h56789ABCDE, 56};
    rows[1] = '{4'd5,  1'b1, 6'd32, 39'h0,          39'h56789ABCDE, 12};
    rows[2] = '{4'd3,  1'b0, 6'd0,  39'h7FFFFFFFFF, 39'h7FFFE00000, 32};
    rows[3] = '{4'd0,  1'b0, 6'd0,  39'h0,          39'h7FFFE00000, 4};
    rows[4] = '{4'd15, 1'b0, 6'd0,  39'h0,          39'h7FFFE00000, 4};
    rows[5] = '{4'd1,  1'b0, 6'd63, 39'h0000000001, 39'h0000000001, 56};
    reset_n = 1'b0;
    clk_en = 1'b1;
    clr = 1'b0;
    req = 1'b0;
    repeat (3) step();
    chk("reset_outputs", {busy, frame_valid, energy, rpt, pitch, kpar, silence, stop, starved, underrun, shift, bytr}, 64'd0);
    reset_n = 1'b1;
    step();

    for (int i = 0; i < 6; i++) begin
      do_clr();
      build(rows[i]);
      for (int j = 0; j < nb; j++) push(by[j]);
      start();
      wait_fv(n);
      chk($sformatf("row%0d_latency", i), n, rows[i].lat);
      chk($sformatf("row%0d_energy", i), energy, rows[i].e);
      chk($sformatf("row%0d_silence", i), silence, rows[i].e == 4'd0);
      chk($sformatf("row%0d_stop", i), stop, rows[i].e == 4'd15);
      chk($sformatf("row%0d_kpar", i), kpar, rows[i].xk);
      if (rows[i].e != 4'd0 && rows[i].e != 4'd15) begin
        chk($sformatf("row%0d_rpt", i), rpt, rows[i].r);
        chk($sformatf("row%0d_pitch", i), pitch, rows[i].p);
      end
      chk($sformatf("row%0d_busy_done", i), busy, 1);
      step();
      chk($sformatf("row%0d_fv_pulse", i), {frame_valid, busy}, 0);
    end

    // silence then stop from the two nibbles of one byte, no clr in between
    do_clr();
    push(8'hF0);
    s0 = nsh;
    b0 = nby;
    start();
    wait_fv(n);
    chk("sil_latency", n, 4);
    chk("sil_flags", {energy, silence, stop}, {4'd0, 1'b1, 1'b0});
    chk("sil_shifts", nsh - s0, 4);
    chk("sil_bytr", nby - b0, 0);
    step();
    s0 = nsh;
    start();
    wait_fv(n);
    chk("stop_latency", n, 4);
    chk("stop_flags", {energy, silence, stop}, {4'd15, 1'b0, 1'b1});
    chk("stop_shifts", nsh - s0, 4);
    chk("stop_bytr_in_done", bytr, 1);
    step();

    // one byte of a voiced frame: u0 stalls, u1 aborts
    do_clr();
    build(rows[0]);
    push(by[0]);
    s0 = nsh;
    b0 = nby;
    f0 = nafv;
    start();
    n = 0;
    while (!starved && n < 50) begin
      step();
      n++;
    end
    chk("starve_seen", starved, 1);
    chk("starve_shifts", nsh - s0, 8);
    chk("starve_bytr", nby - b0, 1);
    chk("starve_busy", busy, 1);
    chk("abort_underrun", a_underrun, 1);
    chk("abort_idle", a_busy, 0);
    repeat (5) step();
    chk("stall_noshift", nsh - s0, 8);
    chk("stall_hold", {starved, busy, underrun}, 3'b110);
    for (int j = 1; j < nb; j++) push(by[j]);
    wait_fv(n);
    chk("resume_fv", frame_valid, 1);
    chk("resume_kpar", kpar, 39'h56789ABCDE);
    chk("resume_fields", {energy, rpt, pitch}, {4'd9, 1'b0, 6'd37});
    chk("resume_not_starved", starved, 0);
    chk("abort_no_fv", nafv - f0, 0);
    step();
    chk("underrun_sticky", a_underrun, 1);
    do_clr();
    chk("clr_underrun", a_underrun, 0);
    chk("clr_busy", {busy, a_busy}, 0);
    chk("clr_keeps_energy", energy, 9);

    // reset in the middle of a frame with clk_en low
    build(rows[0]);
    for (int j = 0; j < nb; j++) push(by[j]);
    start();
    repeat (10) step();
    chk("midframe_busy", busy, 1);
    clk_en = 1'b0;
    reset_n = 1'b0;
    step();
    chk("midreset_outputs", {busy, frame_valid, energy, rpt, pitch, kpar, silence, stop, starved, underrun, shift, bytr}, 64'd0);
    chk("midreset_abort_params", {a_energy, a_pitch, a_kpar, a_busy}, 64'd0);
    reset_n = 1'b1;
    clk_en = 1'b1;
    step();

    chk("shift_bytr_overlap", ovl, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
